// File: rtl/clm_out_reduce_if.sv
// Bus bundle for the redundant-state output reduction block.
// Vectors use descending ranges: the spec-level "index 0" of P, Linv, z and
// ciphertext is the most significant bit here, and spec byte in[k>>2][k&3]
// (flat index k) is element [15-k] of the packed array.
interface clm_out_reduce_if #(
  parameter int unsigned d = 8
);
  localparam int unsigned W = 8 + d;

  logic                  drdy_i;
  logic [15:0][W-1:0]    in;
  logic [8:0]            P;
  logic [7:0][7:0]       Linv;
  logic [127:0]          ciphertext;
  logic                  drdy_o;
  logic                  busy;
  logic                  err;

  modport master (
    output drdy_i, in, P, Linv,
    input  ciphertext, drdy_o, busy, err
  );

  modport slave (
    input  drdy_i, in, P, Linv,
    output ciphertext, drdy_o, busy, err
  );
endinterface

// File: rtl/clm_out_reduce.sv
// Converts a redundant (degree 7+d) final-round state to standard-basis AES
// ciphertext: each byte is reduced modulo P, then mapped through Linv.
// One byte per cycle; 16 cycles of REDUCE followed by a one-cycle DONE.
module clm_out_reduce #(
  parameter int unsigned d = 8
) (
  input  logic             clk,
  input  logic             rst,
  clm_out_reduce_if.slave  bus
);
  localparam int unsigned W = 8 + d;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [15:0][W-1:0] in_q, in_d;
  logic [8:0]         p_q, p_d;
  logic [7:0][7:0]    linv_q, linv_d;
  logic [127:0]       ct_q, ct_d;
  logic               drdy_o_q, drdy_o_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [3:0]         sel;
  logic [W-1:0]       rem;
  logic [7:0]         z;
  logic [7:0]         y;
  logic [6:0]         byte_msb;
  logic               p_valid;

  // P is usable only when its x^8 coefficient (MSB) is set
  assign p_valid = p_q[8];

  // Unrolled GF(2) long division of byte k by P, then the Linv basis change
  always_comb begin
    sel = 4'd15 - k_q;
    rem = in_q[sel];
    for (int n = int'(W) - 1; n >= 8; n--) begin
      if (rem[n]) begin
        rem[n -: 9] = rem[n -: 9] ^ p_q;
      end
    end
    z = rem[7:0];
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(linv_q[i] & z);
    end
  end

  // Byte k lands in the k-th byte from the top of the ciphertext word
  assign byte_msb = 7'(7'd127 - {k_q, 3'b000});

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    in_d     = in_q;
    p_d      = p_q;
    linv_d   = linv_q;
    ct_d     = ct_q;
    err_d    = err_q;
    drdy_o_d = 1'b0;
    busy_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.drdy_i) begin
          in_d    = bus.in;
          p_d     = bus.P;
          linv_d  = bus.Linv;
          err_d   = 1'b0;
          k_d     = 4'd0;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        ct_d[byte_msb -: 8] = p_valid ? y : 8'h00;
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          err_d   = ~p_valid;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    drdy_o_d = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      in_q     <= '0;
      p_q      <= '0;
      linv_q   <= '0;
      ct_q     <= '0;
      drdy_o_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      in_q     <= in_d;
      p_q      <= p_d;
      linv_q   <= linv_d;
      ct_q     <= ct_d;
      drdy_o_q <= drdy_o_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.ciphertext = ct_q;
  assign bus.drdy_o     = drdy_o_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule
